// File: rtl/clb_config_loader.sv
// Bit-serial configuration loader for a chain of NUM_CLB logic blocks (17-bit words, MSB-first).
// Optional trailing even-parity bit and ERROR state are built when CLB_CFG_PARITY_EN is defined.
module clb_config_loader #(
    parameter int NUM_CLB = 4,
    parameter int WORD_W  = 17
) (
    input  logic                        clb_clk,
    input  logic                        clb_rst,
    input  logic                        cfg_start,
    input  logic                        cfg_abort,
    input  logic                        cfg_bit,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    output logic [NUM_CLB*WORD_W-1:0]   prog_bus,
    output logic                        cfg_busy,
    output logic                        cfg_done,
    output logic                        cfg_err,
    output logic                        clb_en
);

    localparam int IDX_W = (NUM_CLB > 1) ? $clog2(NUM_CLB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLB - 1);
    localparam logic [4:0]       LAST_BIT = 5'(WORD_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_DONE   = 3'd2,
        ST_ERROR  = 3'd3
`ifdef CLB_CFG_PARITY_EN
        ,
        ST_PARITY = 3'd4
`endif
    } state_e;

    state_e                      state_q, state_d;
    logic [4:0]                  bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]            clb_idx_q, clb_idx_d;
    logic [WORD_W-1:0]           shift_q, shift_d;
    logic [NUM_CLB*WORD_W-1:0]   prog_q, prog_d;
`ifdef CLB_CFG_PARITY_EN
    logic                        parity_q, parity_d;
`endif

    logic              xfer;
    logic              word_done;
    logic              last_word;
    logic [WORD_W-1:0] shift_nxt;

    assign xfer      = cfg_valid && cfg_ready;
    assign word_done = xfer && (bit_cnt_q == LAST_BIT);
    assign last_word = (clb_idx_q == LAST_IDX);
    assign shift_nxt = {shift_q[WORD_W-2:0], cfg_bit};

    // NOTE: async reset in the sensitivity list and non-blocking updates only; every
    // register (including the prog image) returns to zero the moment clb_rst rises.
    always_ff @(posedge clb_clk or posedge clb_rst) begin
        if (clb_rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            clb_idx_q <= '0;
            shift_q   <= '0;
            prog_q    <= '0;
`ifdef CLB_CFG_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            clb_idx_q <= clb_idx_d;
            shift_q   <= shift_d;
            prog_q    <= prog_d;
`ifdef CLB_CFG_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // Next-state logic; abort has priority over any bit transfer in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (cfg_start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (cfg_abort) begin
                    state_d = ST_IDLE;
                end else if (word_done && last_word) begin
`ifdef CLB_CFG_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef CLB_CFG_PARITY_EN
            ST_PARITY: begin
                if (cfg_abort)  state_d = ST_IDLE;
                else if (xfer)  state_d = (parity_q ^ cfg_bit) ? ST_ERROR : ST_DONE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        cfg_ready = 1'b0;
        cfg_busy  = 1'b0;
        cfg_done  = 1'b0;
        cfg_err   = 1'b0;
        clb_en    = 1'b0;
        case (state_q)
            ST_LOAD: begin
                cfg_ready = 1'b1;
                cfg_busy  = 1'b1;
            end
`ifdef CLB_CFG_PARITY_EN
            ST_PARITY: begin
                cfg_ready = 1'b1;
                cfg_busy  = 1'b1;
            end
            ST_ERROR: cfg_err = 1'b1;
`endif
            ST_DONE: begin
                cfg_done = 1'b1;
                clb_en   = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: staging shift register, counters, slot writes and running parity.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        clb_idx_d = clb_idx_q;
        shift_d   = shift_q;
        prog_d    = prog_q;
`ifdef CLB_CFG_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (cfg_start) begin
                    bit_cnt_d = '0;
                    clb_idx_d = '0;
`ifdef CLB_CFG_PARITY_EN
                    parity_d  = 1'b0;
`endif
                end
            end
            ST_LOAD: begin
                if (cfg_abort) begin
                    prog_d    = '0;
                    bit_cnt_d = '0;
                    clb_idx_d = '0;
                end else if (xfer) begin
                    shift_d = shift_nxt;
`ifdef CLB_CFG_PARITY_EN
                    parity_d = parity_q ^ cfg_bit;
`endif
                    if (word_done) begin
                        prog_d[int'(clb_idx_q)*WORD_W +: WORD_W] = shift_nxt;
                        bit_cnt_d = '0;
                        if (!last_word) clb_idx_d = clb_idx_q + 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
`ifdef CLB_CFG_PARITY_EN
            ST_PARITY: begin
                if (cfg_abort || (xfer && (parity_q ^ cfg_bit))) prog_d = '0;
            end
`endif
            default: ;
        endcase
    end

    assign prog_bus = prog_q;

endmodule

// File: tb/tb_clb_config_loader.sv
// Self-checking bench for clb_config_loader with NUM_CLB=2: table-driven loads with a
// prog_bus scoreboard, plus hand sequences for abort, restart, async reset and parity.
module tb_clb_config_loader;

    localparam int NUM = 2;
    localparam int W   = 17;
    localparam int BUS = NUM * W;

    logic           clb_clk = 1'b0;
    logic           clb_rst = 1'b1;
    logic           cfg_start = 1'b0;
    logic           cfg_abort = 1'b0;
    logic           cfg_bit   = 1'b0;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [BUS-1:0] prog_bus;
    logic           cfg_busy;
    logic           cfg_done;
    logic           cfg_err;
    logic           clb_en;

    clb_config_loader #(.NUM_CLB(NUM), .WORD_W(W)) dut (
        .clb_clk   (clb_clk),
        .clb_rst   (clb_rst),
        .cfg_start (cfg_start),
        .cfg_abort (cfg_abort),
        .cfg_bit   (cfg_bit),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .prog_bus  (prog_bus),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .clb_en    (clb_en)
    );

    always #5 clb_clk = ~clb_clk;

    typedef struct {
        logic [W-1:0]   w0;
        logic [W-1:0]   w1;
        int             gap;       // valid-low cycles inserted after bits 5 and 17
        int             start_at;  // bit number carrying a stray cfg_start (0 = none)
        logic [BUS-1:0] exp_bus;
    } vec_t;

    vec_t           vecs[6];
    logic [BUS-1:0] sb_q[$];
    logic [BUS-1:0] prev_bus = '0;
    int             n_checks = 0;
    int             n_fail   = 0;
    logic           done_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; returns just after the rising edge so outputs are settled.
    task automatic drive(input logic st, input logic ab, input logic vl, input logic b);
        @(negedge clb_clk);
        cfg_start = st;
        cfg_abort = ab;
        cfg_valid = vl;
        cfg_bit   = b;
        @(posedge clb_clk);
        #1;
    endtask

    // Scoreboard consumer: each rising cfg_done must present the next expected image.
    always @(negedge clb_clk) begin
        if (cfg_done && !done_prev) begin
            if (sb_q.size() == 0) check("sb_unexpected_done", 64'(prog_bus), 64'hX);
            else check("sb_prog_bus", 64'(prog_bus), 64'(sb_q.pop_front()));
        end
        done_prev = cfg_done;
    end

    task automatic apply_vec(input vec_t v);
        logic [BUS-1:0] data;
        int             n;
        data = {v.w0, v.w1};
        sb_q.push_back(v.exp_bus);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("start_busy", 64'(cfg_busy), 64'd1);
        check("start_done_clr", 64'({cfg_done, clb_en, cfg_err}), 64'd0);
        for (int i = 0; i < BUS; i++) begin
            n = i + 1;
            drive(logic'(v.start_at == n), 1'b0, 1'b1, data[BUS-1-i]);
            if (n == 16) check("slot0_old_kept", 64'(prog_bus[W-1:0]), 64'(prev_bus[W-1:0]));
            if (n == 17) begin
                check("slot0_written", 64'(prog_bus[W-1:0]), 64'(v.w0));
                check("slot1_old_kept", 64'(prog_bus[BUS-1:W]), 64'(prev_bus[BUS-1:W]));
            end
            if (n == BUS - 1) check("done_early", 64'(cfg_done), 64'd0);
            if ((n == 5 || n == 17) && v.gap > 0) begin
                for (int g = 0; g < v.gap; g++) drive(1'b0, 1'b0, 1'b0, 1'($urandom));
                check("gap_busy", 64'({cfg_busy, cfg_ready, cfg_done}), 64'b110);
            end
        end
`ifdef CLB_CFG_PARITY_EN
        check("parity_wait", 64'({cfg_busy, cfg_done}), 64'b10);
        drive(1'b0, 1'b0, 1'b1, ^data);
`endif
        check("done_level", 64'({cfg_done, clb_en}), 64'b11);
        check("done_idle", 64'({cfg_busy, cfg_ready, cfg_err}), 64'b000);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        check("done_held", 64'({cfg_done, clb_en, cfg_ready}), 64'b110);
        check("done_bus", 64'(prog_bus), 64'(v.exp_bus));
        prev_bus = v.exp_bus;
    endtask

    initial begin
        vecs[0] = '{w0: 17'h12345, w1: 17'h0ABCD, gap: 0, start_at: 0,  exp_bus: 34'h1_579B_2345};
        vecs[1] = '{w0: 17'h12345, w1: 17'h0ABCD, gap: 3, start_at: 0,  exp_bus: 34'h1_579B_2345};
        vecs[2] = '{w0: 17'h1FFFF, w1: 17'h00001, gap: 0, start_at: 10, exp_bus: 34'h0_0003_FFFF};
        vecs[3] = '{w0: 17'h00000, w1: 17'h1FFFF, gap: 1, start_at: 0,  exp_bus: 34'h3_FFFE_0000};
        vecs[4] = '{w0: 17'h15555, w1: 17'h0AAAA, gap: 0, start_at: 0,  exp_bus: 34'h1_5555_5555};
        vecs[5] = '{w0: 17'h00001, w1: 17'h00000, gap: 0, start_at: 0,  exp_bus: 34'h0_0000_0001};

        // Reset state
        #12;
        check("rst_outputs", 64'({cfg_ready, cfg_busy, cfg_done, cfg_err, clb_en}), 64'd0);
        check("rst_bus", 64'(prog_bus), 64'd0);
        @(negedge clb_clk);
        clb_rst = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        check("idle_ignores", 64'({cfg_ready, cfg_busy}), 64'd0);

        for (int k = 0; k < 4; k++) apply_vec(vecs[k]);

        // Abort on the 20th bit: that bit must not land and the image is wiped
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 19; i++) drive(1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        check("abort_status", 64'({cfg_ready, cfg_busy, cfg_done, cfg_err, clb_en}), 64'd0);
        check("abort_bus", 64'(prog_bus), 64'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        check("abort_no_store", 64'(prog_bus), 64'd0);
        prev_bus = '0;
        apply_vec(vecs[4]);

        // Abort ignored in DONE; start+abort together restarts and keeps the old image
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("done_abort_ign", 64'({cfg_done, clb_en}), 64'b11);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check("restart_status", 64'({cfg_busy, cfg_ready, cfg_done, clb_en}), 64'b1100);
        check("restart_bus", 64'(prog_bus), 64'(vecs[4].exp_bus));

        // Asynchronous reset between edges at bit 25
        for (int i = 0; i < 25; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
        #2;
        clb_rst = 1'b1;
        #1;
        check("async_rst_status", 64'({cfg_ready, cfg_busy, cfg_done, cfg_err, clb_en}), 64'd0);
        check("async_rst_bus", 64'(prog_bus), 64'd0);
        @(negedge clb_clk);
        clb_rst = 1'b0;
        prev_bus = '0;

`ifdef CLB_CFG_PARITY_EN
        // All-zero image with parity bit 1 is odd parity -> ERROR
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < BUS; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        check("par_err_status", 64'({cfg_err, cfg_done, clb_en, cfg_busy, cfg_ready}), 64'b10000);
        check("par_err_bus", 64'(prog_bus), 64'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check("par_err_held", 64'(cfg_err), 64'd1);
        prev_bus = '0;
        apply_vec(vecs[5]);
        check("par_ok_err", 64'(cfg_err), 64'd0);
`else
        apply_vec(vecs[5]);
        check("no_parity_err", 64'(cfg_err), 64'd0);
`endif

        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
